// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: stall/flush control plus EXE operand forward selects.
// Define HAZ_PERF_CNT_EN to add saturating stall_count/flush_count performance counters.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_branch,
  input  logic                  bra_taken_id,
  input  logic                  bra_taken_exe,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_flush,
  output logic                  ctrl_flush,
  output logic [1:0]            fwd_a_sel,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
`endif
  output logic [1:0]            fwd_b_sel
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  rs_used;
    logic                  rt_used;
  } slot_t;

  if (CNT_W < 1 || REG_ADDR_W < 1) begin : g_param_check
    $error("pipe_hazard_unit: CNT_W and REG_ADDR_W must be positive");
  end

  slot_t exe_q, mem_q, wb_q;
  slot_t exe_d, mem_d, wb_d;
  logic  hazard_s;

  // R0 is hardwired zero, so a slot targeting it never produces a hazard or forward.
  function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.wr & (s.rd == r) & (r != {REG_ADDR_W{1'b0}});
  endfunction

  function automatic logic id_src_hit(input slot_t s);
    return (id_rs_used & slot_writes(s, id_rs)) | (id_rt_used & slot_writes(s, id_rt));
  endfunction

  // A load in MEM has no ALU result yet, so only WB can supply it.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_ADDR_W-1:0] src,
                                         input slot_t mem, input slot_t wb);
    logic [1:0] sel;
    if (!used) begin
      sel = 2'd0;
    end else if (slot_writes(mem, src) && !mem.is_load) begin
      sel = 2'd1;
    end else if (slot_writes(wb, src)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Hazard detection, stall/flush priority and forward selects.
  always_comb begin
    hazard_s    = id_valid & ((exe_q.is_load & id_src_hit(exe_q)) |
                              (id_is_branch & (id_src_hit(exe_q) | (mem_q.is_load & id_src_hit(mem_q)))));
    stall       = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    ctrl_flush  = 1'b0;
    if (bra_taken_exe) begin
      if_flush   = 1'b1;
      ctrl_flush = 1'b1;
    end else if (hazard_s) begin
      stall       = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_flush  = 1'b1;
    end else if (bra_taken_id) begin
      if_flush = 1'b1;
    end else begin
      if_flush = 1'b0;
    end
    fwd_a_sel = fwd_sel(exe_q.rs_used, exe_q.rs, mem_q, wb_q);
    fwd_b_sel = fwd_sel(exe_q.rt_used, exe_q.rt, mem_q, wb_q);
  end

  // Shadow pipeline advance; a bubble carries all-zero fields.
  always_comb begin
    exe_d = '0;
    if (ctrl_flush || !id_valid) begin
      exe_d = '0;
    end else begin
      exe_d.valid   = 1'b1;
      exe_d.rd      = id_rd;
      exe_d.wr      = id_reg_write;
      exe_d.is_load = id_is_load;
      exe_d.rs      = id_rs;
      exe_d.rt      = id_rt;
      exe_d.rs_used = id_rs_used;
      exe_d.rt_used = id_rt_used;
    end
    mem_d = exe_q;
    wb_d  = mem_q;
  end

  // Shadow slot registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Saturating counters; they stick at all-ones rather than wrap.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
    if ((if_flush || ctrl_flush) && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q <= {CNT_W{1'b0}};
      flush_count_q <= {CNT_W{1'b0}};
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: a queue-based in-flight instruction model produces expectations,
// a negedge monitor compares them. Counter checks are included when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_unit;
  localparam int TB_CNT_W = 2;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rsu;
    logic       rtu;
  } id_t;

  typedef struct packed {
    logic        stall, pc, ifid, ifl, cf;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  logic clock, reset;
  logic id_valid, id_rs_used, id_rt_used, id_reg_write, id_is_load, id_is_branch;
  logic [2:0] id_rs, id_rt, id_rd;
  logic bra_taken_id, bra_taken_exe;
  logic stall, pc_write, if_id_write, if_flush, ctrl_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_count, flush_count;
`endif

  pipe_hazard_unit #(.REG_ADDR_W(3), .CNT_W(TB_CNT_W)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .bra_taken_id(bra_taken_id),
    .bra_taken_exe(bra_taken_exe), .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_flush(if_flush), .ctrl_flush(ctrl_flush), .fwd_a_sel(fwd_a_sel),
`ifdef HAZ_PERF_CNT_EN
    .stall_count(stall_count), .flush_count(flush_count),
`endif
    .fwd_b_sel(fwd_b_sel));

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // Instructions in flight after ID: index 0 = EXE, 1 = MEM, 2 = WB.
  id_t  inflight[$];
  exp_t expq[$];
  id_t  bubble;
  int   sc, fc;
  int   n_chk, n_fail;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit writes(input id_t s, input logic [2:0] r);
    return s.v && s.wr && (s.rd == r) && (r != 3'd0);
  endfunction

  function automatic bit reads_from(input id_t id, input id_t s);
    return (id.rsu && writes(s, id.rs)) || (id.rtu && writes(s, id.rt));
  endfunction

  function automatic logic [1:0] src_from(input bit used, input logic [2:0] r);
    if (!used) return 2'd0;
    if (writes(inflight[1], r) && !inflight[1].ld) return 2'd1;
    if (writes(inflight[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t predict(input id_t id, input bit bid, input bit bex);
    exp_t e;
    bit load_use, br_wait;
    load_use = id.v && inflight[0].ld && reads_from(id, inflight[0]);
    br_wait  = id.v && id.br && (reads_from(id, inflight[0]) ||
                                 (inflight[1].ld && reads_from(id, inflight[1])));
    e = '0;
    e.stall = !bex && (load_use || br_wait);
    e.pc    = !e.stall;
    e.ifid  = !e.stall;
    e.cf    = bex || e.stall;
    e.ifl   = bex || (bid && !e.stall);
    e.fa    = src_from(inflight[0].rsu, inflight[0].rs);
    e.fb    = src_from(inflight[0].rtu, inflight[0].rt);
    e.sc    = sc;
    e.fc    = fc;
    return e;
  endfunction

  function automatic void clear_model();
    inflight.delete();
    repeat (3) inflight.push_back(bubble);
    sc = 0;
    fc = 0;
  endfunction

  function automatic id_t mk(input bit v, input logic [2:0] rd, input bit wr, input bit ld, input bit br,
                             input logic [2:0] rs, input logic [2:0] rt, input bit rsu, input bit rtu);
    id_t i;
    i.v = v; i.rd = rd; i.wr = wr; i.ld = ld; i.br = br;
    i.rs = rs; i.rt = rt; i.rsu = rsu; i.rtu = rtu;
    return i;
  endfunction

  task automatic cycle(input id_t id, input bit bid, input bit bex, input bit rst, output exp_t e);
    reset = rst;
    if (rst) clear_model();
    id_valid = id.v; id_rd = id.rd; id_reg_write = id.wr; id_is_load = id.ld; id_is_branch = id.br;
    id_rs = id.rs; id_rt = id.rt; id_rs_used = id.rsu; id_rt_used = id.rtu;
    bra_taken_id = bid; bra_taken_exe = bex;
    e = predict(id, bid, bex);
    expq.push_back(e);
    @(posedge clock);
    if (rst) begin
      clear_model();
    end else begin
      void'(inflight.pop_back());
      inflight.push_front((e.cf || !id.v) ? bubble : id);
      if (e.stall && sc < CMAX) sc++;
      if ((e.ifl || e.cf) && fc < CMAX) fc++;
    end
    #1;
  endtask

  // Holds an instruction in ID until it is no longer stalled; a flushed fetch becomes a bubble.
  task automatic issue(input id_t id, input bit bid, input bit bex);
    exp_t e;
    int   n;
    n = 0;
    do begin
      cycle(id, bid, bex, 1'b0, e);
      n++;
    end while (e.stall && n < 8);
    if (e.ifl) cycle(bubble, 1'b0, 1'b0, 1'b0, e);
  endtask

  // Monitor: outputs are combinational, so every negedge presents one response.
  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall", stall, e.stall);
      chk("pc_write", pc_write, e.pc);
      chk("if_id_write", if_id_write, e.ifid);
      chk("if_flush", if_flush, e.ifl);
      chk("ctrl_flush", ctrl_flush, e.cf);
      chk("fwd_a_sel", fwd_a_sel, e.fa);
      chk("fwd_b_sel", fwd_b_sel, e.fb);
`ifdef HAZ_PERF_CNT_EN
      chk("stall_count", stall_count, e.sc);
      chk("flush_count", flush_count, e.fc);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    id_t  r;
    bit   bid, bex;
    n_chk = 0; n_fail = 0;
    bubble = '0;
    clear_model();
    reset = 1'b0;
    #1;
    cycle(bubble, 1'b0, 1'b0, 1'b1, e);
    cycle(bubble, 1'b0, 1'b0, 1'b1, e);
    cycle(bubble, 1'b0, 1'b0, 1'b0, e);

    // LW r2 ; ADD r3,r2,r1
    issue(mk(1, 3'd2, 1, 1, 0, 3'd1, 3'd0, 1, 0), 0, 0);
    issue(mk(1, 3'd3, 1, 0, 0, 3'd2, 3'd1, 1, 1), 0, 0);
    issue(bubble, 0, 0);
    // ADD r2 ; SUB r4,r2,r2
    issue(mk(1, 3'd2, 1, 0, 0, 3'd1, 3'd1, 1, 1), 0, 0);
    issue(mk(1, 3'd4, 1, 0, 0, 3'd2, 3'd2, 1, 1), 0, 0);
    issue(bubble, 0, 0);
    // ADD r2 ; ADD r2 ; OR r5,r2,r0
    issue(mk(1, 3'd2, 1, 0, 0, 3'd1, 3'd1, 1, 1), 0, 0);
    issue(mk(1, 3'd2, 1, 0, 0, 3'd3, 3'd3, 1, 1), 0, 0);
    issue(mk(1, 3'd5, 1, 0, 0, 3'd2, 3'd0, 1, 1), 0, 0);
    issue(bubble, 0, 0);
    // ADD r1 ; BEQ r1,r3  then  LW r1 ; BEQ r1,r3 taken in ID
    issue(mk(1, 3'd1, 1, 0, 0, 3'd2, 3'd2, 1, 1), 0, 0);
    issue(mk(1, 3'd0, 0, 0, 1, 3'd1, 3'd3, 1, 1), 0, 0);
    issue(mk(1, 3'd1, 1, 1, 0, 3'd2, 3'd0, 1, 0), 0, 0);
    issue(mk(1, 3'd0, 0, 0, 1, 3'd1, 3'd3, 1, 1), 1, 0);
    // LW r2 ; use r2 with EXE branch taken
    issue(mk(1, 3'd2, 1, 1, 0, 3'd1, 3'd0, 1, 0), 0, 0);
    issue(mk(1, 3'd3, 1, 0, 0, 3'd2, 3'd1, 1, 1), 0, 1);
    // Five load-use stalls drive the 2-bit counters into saturation.
    for (int k = 0; k < 5; k++) begin
      issue(mk(1, 3'd2, 1, 1, 0, 3'd1, 3'd0, 1, 0), 0, 0);
      issue(mk(1, 3'd3, 1, 0, 0, 3'd2, 3'd1, 1, 1), 0, 0);
    end
    // Reset asserted in the middle of a load-use stall.
    cycle(mk(1, 3'd2, 1, 1, 0, 3'd1, 3'd0, 1, 0), 0, 0, 0, e);
    cycle(mk(1, 3'd3, 1, 0, 0, 3'd2, 3'd1, 1, 1), 0, 0, 0, e);
    cycle(mk(1, 3'd3, 1, 0, 0, 3'd2, 3'd1, 1, 1), 0, 0, 1, e);
    cycle(bubble, 0, 0, 1, e);
    cycle(bubble, 0, 0, 0, e);

    for (int k = 0; k < 400; k++) begin
      r.v   = ($urandom % 8) != 0;
      r.rd  = 3'($urandom % 8);
      r.wr  = $urandom % 2;
      r.ld  = r.wr && (($urandom % 3) == 0);
      r.br  = r.v && !r.wr && (($urandom % 3) == 0);
      r.rs  = 3'($urandom % 8);
      r.rt  = 3'($urandom % 8);
      r.rsu = r.v && ($urandom % 4 != 0);
      r.rtu = r.v && ($urandom % 2 != 0);
      bid   = r.br && ($urandom % 2 != 0);
      bex   = ($urandom % 12) == 0;
      issue(r, bid, bex);
    end
    issue(bubble, 0, 0);
    repeat (3) @(negedge clock);
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
